enc_quad_front: RTL and testbench

// - Per-channel encoder front end; feeds the encoder controller's position and period counters.
// - Synchronises the raw asynchronous A/B lines and glitch-filters each one.
// - Decodes the quadrature into a step pulse plus direction.
// - Detects and counts illegal (two-bit) transitions so that host software can flag noisy or miswired encoders.
// - One instance per channel, instantiated inside the encoder controller's generate loop.

---
 rtl/enc_quad_front_pkg.sv | 28 ++
 rtl/enc_quad_front_if.sv | 38 +++
 rtl/enc_quad_front_glitch_filter.sv | 61 ++++++
 rtl/enc_quad_front.sv | 152 +++++++++++++++
 tb/tb_enc_quad_front.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/enc_quad_front_pkg.sv
// Shared constants and types for the quadrature encoder front end.
// Contents:
//   ENC_FILT_LEN_DEFAULT / ENC_ERR_BITS_DEFAULT : default parameter values
//   ENC_SYNC_CYCLES : cycles spent in SYNC while the synchronisers fill
//   ENC_DIR_FWD     : value of dir for forward (A leads B) rotation
//   enc_fe_state_t  : front-end FSM state encodings
//   enc_is_forward  : direction of a single-bit quadrature transition
package enc_quad_front_pkg;

    localparam int   ENC_FILT_LEN_DEFAULT = 8;
    localparam int   ENC_ERR_BITS_DEFAULT = 8;
    localparam int   ENC_SYNC_CYCLES      = 2;
    localparam logic ENC_DIR_FWD          = 1'b1;

    typedef enum logic [1:0] {
        ENC_FE_SYNC = 2'd0,
        ENC_FE_LOAD = 2'd1,
        ENC_FE_RUN  = 2'd2
    } enc_fe_state_t;

    // For a single-bit change on the forward sequence 00->10->11->01->00
    // the new A always differs from the old B; on the reverse sequence
    // they are equal. Only meaningful when exactly one bit changed.
    function automatic logic enc_is_forward(input logic [1:0] prev, input logic [1:0] cur);
        return prev[0] ^ cur[1];
    endfunction

endpackage

// File: rtl/enc_quad_front_if.sv
// Channel bus of the encoder front end.
// Signals:
//   enc_a, enc_b   raw asynchronous encoder lines       (master -> slave)
//   clr_err        1-cycle error clear pulse             (master -> slave)
//   a_filt, b_filt filtered lines                        (slave -> master)
//   step, dir      step pulse and direction              (slave -> master)
//   err            illegal-transition pulse              (slave -> master)
//   err_cnt        saturating illegal-transition count   (slave -> master)
//   err_sticky     latched error flag                    (slave -> master)
//   ready          decoder live                          (slave -> master)
// ERR_BITS must match the ERR_BITS of the enc_quad_front it connects to.
interface enc_quad_front_if
    import enc_quad_front_pkg::*;
#(
    parameter int ERR_BITS = ENC_ERR_BITS_DEFAULT
);
    logic                enc_a;
    logic                enc_b;
    logic                clr_err;
    logic                a_filt;
    logic                b_filt;
    logic                step;
    logic                dir;
    logic                err;
    logic [ERR_BITS-1:0] err_cnt;
    logic                err_sticky;
    logic                ready;

    modport master (
        output enc_a, enc_b, clr_err,
        input  a_filt, b_filt, step, dir, err, err_cnt, err_sticky, ready
    );

    modport slave (
        input  enc_a, enc_b, clr_err,
        output a_filt, b_filt, step, dir, err, err_cnt, err_sticky, ready
    );
endinterface

// File: rtl/enc_quad_front_glitch_filter.sv
// One encoder line: 2-FF synchroniser followed by a counting glitch filter.
// Ports:
//   sysclk  in   clock
//   reset   in   asynchronous active-low reset
//   raw     in   raw asynchronous line
//   load    in   copy the synchronised value straight into filt
//   synced  out  synchronised line (2 cycles behind raw)
//   filt    out  filtered line; toggles after FILT_LEN consecutive mismatches
module enc_quad_front_glitch_filter
    import enc_quad_front_pkg::*;
#(
    parameter int FILT_LEN = ENC_FILT_LEN_DEFAULT
) (
    input  logic sysclk,
    input  logic reset,
    input  logic raw,
    input  logic load,
    output logic synced,
    output logic filt
);

    localparam int             CW   = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(FILT_LEN - 1);

    logic          sync1;
    logic [CW-1:0] cnt;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            synced <= 1'b0;
        end else begin
            sync1  <= raw;
            synced <= sync1;
        end
    end

    // The counter only survives while the mismatch persists, so the
    // output moves on the FILT_LEN-th consecutive mismatching edge and any
    // shorter excursion is thrown away.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            filt <= synced;
            cnt  <= '0;
        end else if (synced != filt) begin
            if (cnt == LAST) begin
                filt <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/enc_quad_front.sv
// Per-channel quadrature encoder front end.
// Ports:
//   sysclk  in   global clock
//   reset   in   asynchronous active-low reset
//   bus     slave modport of enc_quad_front_if:
//           enc_a/enc_b/clr_err in; a_filt/b_filt/step/dir/err/err_cnt/
//           err_sticky/ready out
// Holds the SYNC/LOAD/RUN sequencer, the quadrature decoder and the
// saturating illegal-transition counter; the two lines are conditioned by
// enc_quad_front_glitch_filter instances.
module enc_quad_front
    import enc_quad_front_pkg::*;
#(
    parameter int FILT_LEN = ENC_FILT_LEN_DEFAULT,
    parameter int ERR_BITS = ENC_ERR_BITS_DEFAULT
) (
    input  logic              sysclk,
    input  logic              reset,
    enc_quad_front_if.slave   bus
);

    enc_fe_state_t       state;
    enc_fe_state_t       next_state;
    logic [1:0]          sync_cnt;

    logic                load_en;
    logic                run_en;

    logic                a_s;
    logic                b_s;
    logic                a_filt;
    logic                b_filt;

    logic [1:0]          prev;
    logic [1:0]          cur;
    logic [1:0]          diff;
    logic                valid_edge;
    logic                illegal_edge;

    logic                step_q;
    logic                dir_q;
    logic                err_q;
    logic [ERR_BITS-1:0] err_cnt_q;
    logic                err_sticky_q;

    enc_quad_front_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (bus.enc_a),
        .load   (load_en),
        .synced (a_s),
        .filt   (a_filt)
    );

    enc_quad_front_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (bus.enc_b),
        .load   (load_en),
        .synced (b_s),
        .filt   (b_filt)
    );

    // State register; sync_cnt measures the time spent in SYNC.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= ENC_FE_SYNC;
            sync_cnt <= '0;
        end else begin
            state    <= next_state;
            sync_cnt <= (state == ENC_FE_SYNC) ? sync_cnt + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ENC_FE_SYNC: if (sync_cnt == 2'(ENC_SYNC_CYCLES - 1)) next_state = ENC_FE_LOAD;
            ENC_FE_LOAD: next_state = ENC_FE_RUN;
            ENC_FE_RUN:  next_state = ENC_FE_RUN;
            default:     next_state = ENC_FE_SYNC;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        run_en  = 1'b0;
        case (state)
            ENC_FE_LOAD: load_en = 1'b1;
            ENC_FE_RUN:  run_en  = 1'b1;
            default:     ;
        endcase
    end

    // Edge classification of the filtered pair against the last accepted state.
    always_comb begin
        cur          = {a_filt, b_filt};
        diff         = cur ^ prev;
        valid_edge   = run_en && (diff == 2'b01 || diff == 2'b10);
        illegal_edge = run_en && (diff == 2'b11);
    end

    // Decoder. LOAD seeds prev from the synchronisers (the filters are being
    // loaded with the same values on this edge) so RUN starts with no edge.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            prev   <= 2'b00;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            step_q <= valid_edge;
            err_q  <= illegal_edge;
            if (load_en) begin
                prev <= {a_s, b_s};
            end else if (run_en) begin
                prev <= cur;
            end
            if (valid_edge) begin
                dir_q <= enc_is_forward(prev, cur) ? ENC_DIR_FWD : ~ENC_DIR_FWD;
            end
        end
    end

    // Error counter: a simultaneous clear and error leaves a count of one.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else if (illegal_edge) begin
            err_sticky_q <= 1'b1;
            if (bus.clr_err) begin
                err_cnt_q <= ERR_BITS'(1);
            end else if (!(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + ERR_BITS'(1);
            end
        end else if (bus.clr_err) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end
    end

    assign bus.a_filt     = a_filt;
    assign bus.b_filt     = b_filt;
    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.err        = err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.ready      = run_en;

endmodule

// File: tb/tb_enc_quad_front.sv
// Directed self-checking bench for enc_quad_front (FILT_LEN=8, ERR_BITS=8).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, so a value seen after N ticks is the one
// registered on the N-th edge after the stimulus.
module tb_enc_quad_front;

    logic sysclk = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;
    int step_seen;
    int afilt_seen;
    int err_seen;

    enc_quad_front_if #(.ERR_BITS(8)) bus ();

    enc_quad_front #(.FILT_LEN(8), .ERR_BITS(8)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles while tallying step, a_filt-high and err samples.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.step)   step_seen++;
            if (bus.a_filt) afilt_seen++;
            if (bus.err)    err_seen++;
        end
    endtask

    // One quadrature state with a 20-cycle dwell: step must appear exactly
    // 11 cycles after the raw change and last one cycle.
    task automatic apply_stimulus(input logic a, input logic b, input logic exp_dir, input string tag);
        bus.enc_a = a;
        bus.enc_b = b;
        repeat (10) tick();
        check_output({tag, "_early"}, bus.step, 1'b0);
        tick();
        check_output({tag, "_step"}, bus.step, 1'b1);
        check_output({tag, "_dir"}, bus.dir, exp_dir);
        tick();
        check_output({tag, "_one"}, bus.step, 1'b0);
        repeat (8) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ready"}, bus.ready, 1'b0);
        check_output({tag, "_afilt"}, bus.a_filt, 1'b0);
        check_output({tag, "_bfilt"}, bus.b_filt, 1'b0);
        check_output({tag, "_step"}, bus.step, 1'b0);
        check_output({tag, "_dir"}, bus.dir, 1'b0);
        check_output({tag, "_err"}, bus.err, 1'b0);
        check_output({tag, "_errcnt"}, bus.err_cnt, 8'd0);
        check_output({tag, "_sticky"}, bus.err_sticky, 1'b0);
    endtask

    initial begin
        // Power-up with both lines high.
        reset       = 1'b0;
        bus.enc_a   = 1'b1;
        bus.enc_b   = 1'b1;
        bus.clr_err = 1'b0;
        repeat (3) tick();
        check_all_zero("rst");

        reset = 1'b1;
        tick();
        check_output("pwr_ready_c1", bus.ready, 1'b0);
        tick();
        check_output("pwr_ready_c2", bus.ready, 1'b0);
        tick();
        check_output("pwr_ready", bus.ready, 1'b1);
        check_output("pwr_afilt", bus.a_filt, 1'b1);
        check_output("pwr_bfilt", bus.b_filt, 1'b1);
        check_output("pwr_errcnt", bus.err_cnt, 8'd0);
        check_output("pwr_step", bus.step, 1'b0);
        step_seen = 0; err_seen = 0; afilt_seen = 0;
        watch(5);
        check_output("pwr_quiet_step", step_seen, 0);
        check_output("pwr_quiet_err", err_seen, 0);

        // Walk from 11 to 00 forwards, then a full forward and reverse cycle.
        $display("[TB] forward rotation");
        apply_stimulus(1'b0, 1'b1, 1'b1, "pre1");
        apply_stimulus(1'b0, 1'b0, 1'b1, "pre2");
        apply_stimulus(1'b1, 1'b0, 1'b1, "fwd1");
        apply_stimulus(1'b1, 1'b1, 1'b1, "fwd2");
        apply_stimulus(1'b0, 1'b1, 1'b1, "fwd3");
        apply_stimulus(1'b0, 1'b0, 1'b1, "fwd4");
        $display("[TB] reverse rotation");
        apply_stimulus(1'b0, 1'b1, 1'b0, "rev1");
        apply_stimulus(1'b1, 1'b1, 1'b0, "rev2");
        apply_stimulus(1'b1, 1'b0, 1'b0, "rev3");
        apply_stimulus(1'b0, 1'b0, 1'b0, "rev4");

        // 7-cycle glitch on A is rejected.
        $display("[TB] glitch rejection");
        step_seen = 0; afilt_seen = 0;
        bus.enc_a = 1'b1;
        watch(7);
        bus.enc_a = 1'b0;
        watch(20);
        check_output("glitch7_step", step_seen, 0);
        check_output("glitch7_afilt", afilt_seen, 0);

        // 8-cycle pulse passes: a_filt high for 8 cycles, forward then reverse step.
        step_seen = 0; afilt_seen = 0;
        bus.enc_a = 1'b1;
        watch(8);
        bus.enc_a = 1'b0;
        watch(30);
        check_output("glitch8_step", step_seen, 2);
        check_output("glitch8_afilt", afilt_seen, 8);
        check_output("glitch8_dir", bus.dir, 1'b0);

        // Illegal 00 -> 11.
        $display("[TB] illegal transition");
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b1;
        repeat (10) tick();
        check_output("ill_early", bus.err, 1'b0);
        tick();
        check_output("ill_err", bus.err, 1'b1);
        check_output("ill_step", bus.step, 1'b0);
        check_output("ill_errcnt", bus.err_cnt, 8'd1);
        check_output("ill_sticky", bus.err_sticky, 1'b1);
        check_output("ill_dir", bus.dir, 1'b0);
        tick();
        check_output("ill_one", bus.err, 1'b0);
        repeat (8) tick();

        // 300 more illegal toggles: count saturates at 255.
        step_seen = 0; err_seen = 0;
        for (int i = 0; i < 300; i++) begin
            bus.enc_a = ~bus.enc_a;
            bus.enc_b = ~bus.enc_b;
            watch(12);
            if (i == 252) check_output("sat_254", bus.err_cnt, 8'd254);
        end
        check_output("sat_pulses", err_seen, 300);
        check_output("sat_errcnt", bus.err_cnt, 8'd255);
        check_output("sat_sticky", bus.err_sticky, 1'b1);
        check_output("sat_step", step_seen, 0);
        check_output("sat_dir", bus.dir, 1'b0);

        // clr_err alone.
        $display("[TB] error clear");
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check_output("clr_errcnt", bus.err_cnt, 8'd0);
        check_output("clr_sticky", bus.err_sticky, 1'b0);
        tick();
        check_output("clr_hold", bus.err_cnt, 8'd0);

        // clr_err coincident with an illegal 11 -> 00 edge: error wins.
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        repeat (10) tick();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check_output("clrwin_err", bus.err, 1'b1);
        check_output("clrwin_errcnt", bus.err_cnt, 8'd1);
        check_output("clrwin_sticky", bus.err_sticky, 1'b1);
        repeat (8) tick();

        // Reset while stepping.
        $display("[TB] mid-run reset");
        bus.enc_a = 1'b1;
        repeat (11) tick();
        check_output("mid_step", bus.step, 1'b1);
        check_output("mid_dir", bus.dir, 1'b1);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        #2;
        reset = 1'b1;
        tick();
        check_output("mid_ready_c1", bus.ready, 1'b0);
        tick();
        check_output("mid_ready_c2", bus.ready, 1'b0);
        tick();
        check_output("mid_ready", bus.ready, 1'b1);
        check_output("mid_afilt", bus.a_filt, 1'b1);
        check_output("mid_bfilt", bus.b_filt, 1'b0);
        check_output("mid_err", bus.err, 1'b0);
        step_seen = 0; err_seen = 0;
        watch(10);
        check_output("mid_quiet_err", err_seen, 0);
        check_output("mid_quiet_step", step_seen, 0);
        check_output("mid_errcnt", bus.err_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
